// File: rtl/rst_initiator.sv
// rtl/rst_initiator.sv - reset pulse generator with FIFO reset-busy handshake
// Optional timeout watchdog enabled by RST_INITIATOR_TIMEOUT_EN.
module rst_initiator #(
    parameter int HOLD_CYCLES    = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic fifo_rst_busy,
    output logic rst_out,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    // Both counters share the timeout width; TIMEOUT_CYCLES always exceeds HOLD_CYCLES.
    localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fb_s;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic                   rst_out_d, busy_d, done_d;
    logic                   tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fifo_rst_busy};
        end
    end

    assign fb_s = sync_q[SYNC_STAGES-1];

`ifdef RST_INITIATOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_q;
    logic             tmo_err_q;

    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
            if ((state_q == S_IDLE) && req) begin
                tmo_err_q <= 1'b0;
            end else if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            rst_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rst_out <= rst_out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rst_out_d = rst_out;
        busy_d    = busy;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_ASSERT;
                    rst_out_d = 1'b1;
                    busy_d    = 1'b1;
                    hold_d    = '0;
                end
            end
            S_ASSERT: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + CNT_W'(1);
                end
                // hold_q lags the edge count by one, so HOLD_LAST marks the final hold cycle
                if ((hold_q >= HOLD_LAST) && fb_s) begin
                    state_d   = S_RELEASE;
                    rst_out_d = 1'b0;
                end
            end
            S_RELEASE: begin
                if (!fb_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rst_out_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
        if (tmo_hit) begin
            state_d   = S_IDLE;
            rst_out_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_rst_initiator.sv
// tb/tb_rst_initiator.sv - table-driven bench for rst_initiator
module tb_rst_initiator;

    localparam int HOLD = 8;
    localparam int SYNC = 3;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic fifo_rst_busy = 1'b0;
    logic rst_out, busy, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       rn;
        logic       rq;
        logic       fb;
        int         n;
        logic [3:0] exp;   // {rst_out, busy, done, timeout_err}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rst_initiator #(
        .HOLD_CYCLES(HOLD),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .fifo_rst_busy(fifo_rst_busy),
        .rst_out(rst_out),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    function automatic logic [3:0] outs();
        return {rst_out, busy, done, timeout_err};
    endfunction

    task automatic add(input logic rn, input logic rq, input logic fb, input int n, input logic [3:0] e);
        vec_t v;
        v.rn = rn; v.rq = rq; v.fb = fb; v.n = n; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d..%0d", name, cyc, got, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst_n         = vecs[i].rn;
            req           = vecs[i].rq;
            fifo_rst_busy = vecs[i].fb;
            for (int j = 0; j < vecs[i].n; j++) begin
                tick();
                check($sformatf("vec%0d.%0d", i, j), outs(), vecs[i].exp);
            end
        end
    endtask

    int m_nom, m_slow, m_tmo, m_fast, m_end;

    initial begin
        int dones, width, budget;
        logic [1:0] hist;
        logic prev_done;

        // reset held with req and feedback active, then quiet idle
        add(0, 1, 1, 3, 4'b0000);
        add(1, 0, 0, 5, 4'b0000);
        // nominal: feedback up 2 cycles after rst_out, down 10 cycles after it falls
        m_nom = vecs.size();
        add(1, 1, 0, 1,  4'b1100);
        add(1, 0, 0, 2,  4'b1100);
        add(1, 0, 1, 5,  4'b1100);
        add(1, 0, 1, 11, 4'b0100);
        add(1, 0, 0, 3,  4'b0100);
        add(1, 0, 0, 1,  4'b0010);
        add(1, 0, 0, 3,  4'b0000);
        // slow ack with an ignored second request
        m_slow = vecs.size();
        add(1, 1, 0, 1,  4'b1100);
        add(1, 0, 0, 4,  4'b1100);
        add(1, 1, 0, 1,  4'b1100);
        add(1, 0, 0, 14, 4'b1100);
        add(1, 0, 1, 3,  4'b1100);
        add(1, 0, 1, 8,  4'b0100);
        add(1, 0, 0, 3,  4'b0100);
        add(1, 0, 0, 1,  4'b0010);
        add(1, 0, 0, 4,  4'b0000);
        // no feedback at all
        m_tmo = vecs.size();
`ifdef RST_INITIATOR_TIMEOUT_EN
        add(1, 1, 0, 1,  4'b1100);
        add(1, 0, 0, 63, 4'b1100);
        add(1, 0, 0, 1,  4'b0001);
        add(1, 0, 0, 4,  4'b0001);
`else
        add(1, 1, 0, 1,  4'b1100);
        add(1, 0, 0, 99, 4'b1100);
        add(1, 0, 1, 3,  4'b1100);
        add(1, 0, 1, 2,  4'b0100);
        add(1, 0, 0, 3,  4'b0100);
        add(1, 0, 0, 1,  4'b0010);
        add(1, 0, 0, 2,  4'b0000);
`endif
        // feedback already present when hold completes: width exactly HOLD
        m_fast = vecs.size();
        add(1, 1, 0, 1, 4'b1100);
        add(1, 0, 1, 7, 4'b1100);
        add(1, 0, 1, 3, 4'b0100);
        add(1, 0, 0, 3, 4'b0100);
        add(1, 0, 0, 1, 4'b0010);
        add(1, 0, 0, 2, 4'b0000);
        m_end = vecs.size();

        run_range(0, m_end);

        // mid-sequence asynchronous reset
        req = 1'b1;
        tick();
        check("mid_accept", outs(), 4'b1100);
        req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", outs(), 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_in_reset", outs(), 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_quiet", outs(), 4'b0000);
        end
        run_range(m_nom, m_slow);

        // back-to-back with req held high and a FIFO echoing rst_out 2 cycles late
        req = 1'b1;
        fifo_rst_busy = 1'b0;
        dones = 0;
        width = 0;
        budget = 0;
        hist = 2'b00;
        prev_done = 1'b0;
        while (dones < 3 && budget < 300) begin
            tick();
            budget++;
            if (prev_done) begin
                check("b2b_reaccept", outs(), 4'b1100);
            end
            if (rst_out) begin
                width++;
            end else if (width != 0) begin
                check_int("b2b_width", width, HOLD, 1000);
                width = 0;
            end
            if (done) begin
                dones++;
            end
            prev_done = done;
            fifo_rst_busy = hist[1];
            hist = {hist[0], rst_out};
        end
        check_int("b2b_done_count", dones, 3, 3);
        req = 1'b0;
        fifo_rst_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check("b2b_idle", outs(), 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
